// File: rtl/bullet_pool_pkg.sv
// Shared constants, types and the heading-to-velocity helper for the bullet engine.
package bullet_pkg;
  localparam int COORD_W      = 10;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef logic [COORD_W-1:0] coord_t;
  // Wide signed container; the engine truncates to COORD_W+FRAC_W+1 bits.
  typedef logic signed [31:0] vel_t;

  // Sign-magnitude trig (127 = 1.0) scaled by speed: |v| = (speed*mag) >> 7.
  // A zero magnitude yields zero whatever the sign bit says.
  function automatic vel_t trig_to_vel(input int speed, input logic [7:0] trig);
    vel_t mag;
    mag = vel_t'((speed * int'({25'd0, trig[6:0]})) >>> 7);
    return trig[7] ? -mag : mag;
  endfunction
endpackage

// File: rtl/bullet_pool_if.sv
// Tank/collision-side bundle of the bullet pool.
interface bullet_pool_if import bullet_pkg::*; #(
  parameter int NUM_BULLETS = 5
);
  logic                           fire;
  coord_t                         tankX, tankY;
  logic [7:0]                     sin, cos;
  logic [NUM_BULLETS-1:0]         wall_top, wall_bottom, wall_left, wall_right;
  logic [NUM_BULLETS-1:0]         hit;
  logic [NUM_BULLETS-1:0]         active;
  logic [COORD_W*NUM_BULLETS-1:0] bullet_x, bullet_y;
  logic                           fire_ack, fire_drop;

  modport master (
    output fire, tankX, tankY, sin, cos, wall_top, wall_bottom, wall_left, wall_right, hit,
    input  active, bullet_x, bullet_y, fire_ack, fire_drop
  );
  modport slave (
    input  fire, tankX, tankY, sin, cos, wall_top, wall_bottom, wall_left, wall_right, hit,
    output active, bullet_x, bullet_y, fire_ack, fire_drop
  );
endinterface

// File: rtl/bullet_pool_slot.sv
// One bullet: spawn, per-frame move with wall reflection, retire on hit/age/bounces/off-screen.
module bullet_slot import bullet_pkg::*; #(
  parameter int LIFETIME    = 1000,
  parameter int MAX_BOUNCES = 8,
  parameter int FRAC_W      = 4
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             spawn,
  input  logic [COORD_W+FRAC_W:0]          spawn_x,
  input  logic [COORD_W+FRAC_W:0]          spawn_y,
  input  logic signed [COORD_W+FRAC_W:0]   spawn_vx,
  input  logic signed [COORD_W+FRAC_W:0]   spawn_vy,
  input  logic                             wall_top,
  input  logic                             wall_bottom,
  input  logic                             wall_left,
  input  logic                             wall_right,
  input  logic                             hit,
  output logic                             active,
  output coord_t                           x,
  output coord_t                           y
);
  localparam int POS_W = COORD_W + FRAC_W + 1;
  localparam int AGE_W = $clog2(LIFETIME + 1);
  localparam int BN_W  = $clog2(MAX_BOUNCES + 2);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LIVE = 1'b1;
  localparam logic [COORD_W:0] X_LIM = SCREEN_X_MAX[COORD_W:0];
  localparam logic [COORD_W:0] Y_LIM = SCREEN_Y_MAX[COORD_W:0];

  logic [0:0]              state;
  logic [POS_W-1:0]        px, py, npx, npy;
  logic signed [POS_W-1:0] vx, vy, nvx, nvy;
  logic [AGE_W-1:0]        age;
  logic [BN_W-1:0]         bounces;
  logic                    any_wall, off_screen;

  // Next velocity/position; integer part is treated unsigned so a negative wrap lands > limit.
  always_comb begin
    any_wall   = wall_top | wall_bottom | wall_left | wall_right;
    nvx        = (wall_left | wall_right) ? -vx : vx;
    nvy        = (wall_top  | wall_bottom) ? -vy : vy;
    npx        = px + POS_W'(nvx);
    npy        = py + POS_W'(nvy);
    off_screen = (npx[POS_W-1:FRAC_W] > X_LIM) || (npy[POS_W-1:FRAC_W] > Y_LIM);
  end

  // IDLE -> LIVE on spawn; LIVE -> IDLE on the first retire condition in priority order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      px      <= '0;
      py      <= '0;
      vx      <= '0;
      vy      <= '0;
      age     <= '0;
      bounces <= '0;
    end else if (state == S_IDLE) begin
      if (spawn) begin
        state   <= S_LIVE;
        px      <= spawn_x;
        py      <= spawn_y;
        vx      <= spawn_vx;
        vy      <= spawn_vy;
        age     <= '0;
        bounces <= '0;
      end
    end else begin
      if (hit) begin
        state <= S_IDLE;
      end else if (age == AGE_W'(LIFETIME - 1)) begin
        state <= S_IDLE;
      end else if (any_wall && MAX_BOUNCES != 0 && bounces == BN_W'(MAX_BOUNCES)) begin
        state <= S_IDLE;
      end else begin
        vx  <= nvx;
        vy  <= nvy;
        px  <= npx;
        py  <= npy;
        age <= age + 1'b1;
        if (any_wall && bounces != '1) bounces <= bounces + 1'b1;
        if (off_screen) state <= S_IDLE;
      end
    end
  end

  assign active = (state == S_LIVE);
  assign x      = px[FRAC_W +: COORD_W];
  assign y      = py[FRAC_W +: COORD_W];
endmodule

// File: rtl/bullet_pool.sv
// Multi-bullet engine: fire-edge detect, cooldown, lowest-free-slot allocator, slot array.
module bullet_pool import bullet_pkg::*; #(
  parameter int NUM_BULLETS  = 5,
  parameter int LIFETIME     = 1000,
  parameter int MAX_BOUNCES  = 8,
  parameter int COOLDOWN     = 10,
  parameter int SPEED        = 32,
  parameter int FRAC_W       = 4,
  parameter int SPAWN_OFFSET = 4
)(
  input  logic         frame_clk,
  input  logic         Reset,
  bullet_pool_if.slave bus
);
  localparam int POS_W = COORD_W + FRAC_W + 1;
  localparam int CD_W  = $clog2(COOLDOWN + 2);

  logic                                  fire_q, fire_edge, free_found, do_spawn;
  logic                                  fire_ack, fire_drop;
  logic [CD_W-1:0]                       cooldown;
  logic [NUM_BULLETS-1:0]                active, alloc;
  logic signed [POS_W-1:0]               vx, vy;
  logic [POS_W-1:0]                      spawn_x, spawn_y;
  logic [NUM_BULLETS-1:0][COORD_W-1:0]   xs, ys;

  // Launch vector and muzzle position from the current heading and tank centre.
  always_comb begin
    vx      = POS_W'(trig_to_vel(SPEED, bus.cos));
    vy      = POS_W'(-trig_to_vel(SPEED, bus.sin));
    spawn_x = POS_W'({bus.tankX, {FRAC_W{1'b0}}}) + POS_W'(SPAWN_OFFSET) * POS_W'(vx);
    spawn_y = POS_W'({bus.tankY, {FRAC_W{1'b0}}}) + POS_W'(SPAWN_OFFSET) * POS_W'(vy);
  end

  // Lowest idle slot wins; uses registered active so a slot freed this frame waits one frame.
  always_comb begin
    alloc      = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !free_found) begin
        alloc[i]   = 1'b1;
        free_found = 1'b1;
      end
    end
    fire_edge = bus.fire & ~fire_q;
    do_spawn  = fire_edge && (cooldown == '0) && free_found;
  end

  // Edge history, cooldown and the ack/drop pulses.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      fire_q    <= 1'b0;
      cooldown  <= '0;
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
    end else begin
      fire_q    <= bus.fire;
      fire_ack  <= do_spawn;
      fire_drop <= fire_edge & ~do_spawn;
      if (do_spawn)             cooldown <= CD_W'(COOLDOWN);
      else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .LIFETIME(LIFETIME), .MAX_BOUNCES(MAX_BOUNCES), .FRAC_W(FRAC_W)
    ) u_slot (
      .clk        (frame_clk),
      .rst        (Reset),
      .spawn      (do_spawn & alloc[i]),
      .spawn_x    (spawn_x),
      .spawn_y    (spawn_y),
      .spawn_vx   (vx),
      .spawn_vy   (vy),
      .wall_top   (bus.wall_top[i]),
      .wall_bottom(bus.wall_bottom[i]),
      .wall_left  (bus.wall_left[i]),
      .wall_right (bus.wall_right[i]),
      .hit        (bus.hit[i]),
      .active     (active[i]),
      .x          (xs[i]),
      .y          (ys[i])
    );
  end

  assign bus.active    = active;
  assign bus.bullet_x  = xs;
  assign bus.bullet_y  = ys;
  assign bus.fire_ack  = fire_ack;
  assign bus.fire_drop = fire_drop;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: spawn, allocation, cooldown, bounce, lifetime, reset.
module tb_bullet_pool;
  logic clk, rst;
  int total = 0;
  int bad   = 0;

  bullet_pool_if #(.NUM_BULLETS(5)) ifa ();
  bullet_pool_if #(.NUM_BULLETS(5)) ifb ();

  bullet_pool u_a (.frame_clk(clk), .Reset(rst), .bus(ifa.slave));
  bullet_pool #(.MAX_BOUNCES(2)) u_b (.frame_clk(clk), .Reset(rst), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.fire = 0; ifa.tankX = 10'd100; ifa.tankY = 10'd200; ifa.sin = 8'h00; ifa.cos = 8'h7F;
    ifa.wall_top = '0; ifa.wall_bottom = '0; ifa.wall_left = '0; ifa.wall_right = '0; ifa.hit = '0;
    ifb.fire = 0; ifb.tankX = 10'd100; ifb.tankY = 10'd200; ifb.sin = 8'h7F; ifb.cos = 8'h7F;
    ifb.wall_top = '0; ifb.wall_bottom = '0; ifb.wall_left = '0; ifb.wall_right = '0; ifb.hit = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  // One-frame fire pulse; returns just after the edge that samples it.
  task automatic pulse(input bit on_b);
    if (on_b) ifb.fire = 1; else ifa.fire = 1;
    tick();
    ifa.fire = 0;
    ifb.fire = 0;
  endtask

  int n;

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    chk("rst_active", 32'(ifa.active), 0);
    chk("rst_ack", 32'(ifa.fire_ack), 0);
    chk("rst_x", 32'(ifa.bullet_x[9:0]), 0);
    rst = 0;
    tick();

    // Basic spawn and first move: x 1724 -> 1755 sub-pixels
    pulse(0);
    chk("spawn_ack", 32'(ifa.fire_ack), 1);
    chk("spawn_active", 32'(ifa.active), 1);
    chk("spawn_x", 32'(ifa.bullet_x[9:0]), 107);
    chk("spawn_y", 32'(ifa.bullet_y[9:0]), 200);
    tick();
    chk("ack_pulse", 32'(ifa.fire_ack), 0);
    chk("move_x", 32'(ifa.bullet_x[9:0]), 109);
    chk("move_y", 32'(ifa.bullet_y[9:0]), 200);

    // Sign handling: cos negative -> vx=-31; zero-magnitude sin gives vy=0
    do_reset();
    ifa.cos = 8'hFF; ifa.sin = 8'h80;
    pulse(0);
    chk("neg_x", 32'(ifa.bullet_x[9:0]), 92);
    chk("zero_y", 32'(ifa.bullet_y[9:0]), 200);

    // Fill all slots, overflow drop, hit frees slot 2, refill
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(0);
      chk("fill_ack", 32'(ifa.fire_ack), 1);
      chk("fill_active", 32'(ifa.active), (32'd1 << (i + 1)) - 1);
      repeat (10) tick();
    end
    pulse(0);
    chk("full_drop", 32'(ifa.fire_drop), 1);
    chk("full_ack", 32'(ifa.fire_ack), 0);
    ifa.hit = 5'b00100;
    tick();
    ifa.hit = '0;
    chk("hit_active", 32'(ifa.active), 5'b11011);
    chk("drop_pulse", 32'(ifa.fire_drop), 0);
    pulse(0);
    chk("realloc_ack", 32'(ifa.fire_ack), 1);
    chk("realloc_active", 32'(ifa.active), 5'b11111);

    // Cooldown: edge 3 frames after spawn refused, 11 frames after accepted
    do_reset();
    pulse(0);
    tick();
    tick();
    pulse(0);
    chk("cd_drop", 32'(ifa.fire_drop), 1);
    chk("cd_active", 32'(ifa.active), 1);
    repeat (7) tick();
    pulse(0);
    chk("cd_ok_ack", 32'(ifa.fire_ack), 1);
    chk("cd_ok_active", 32'(ifa.active), 3);

    // Bounces on the MAX_BOUNCES=2 instance, vx=+31 vy=-31
    do_reset();
    pulse(1);
    chk("b_spawn_x", 32'(ifb.bullet_x[9:0]), 107);
    chk("b_spawn_y", 32'(ifb.bullet_y[9:0]), 192);
    ifb.wall_right = 5'b00001; ifb.wall_top = 5'b00001;
    tick();
    ifb.wall_right = '0; ifb.wall_top = '0;
    chk("corner_x", 32'(ifb.bullet_x[9:0]), 105);
    chk("corner_y", 32'(ifb.bullet_y[9:0]), 194);
    tick();
    chk("after_x", 32'(ifb.bullet_x[9:0]), 103);
    chk("after_y", 32'(ifb.bullet_y[9:0]), 196);
    ifb.wall_left = 5'b00001;
    tick();
    ifb.wall_left = '0;
    chk("b2_active", 32'(ifb.active), 1);
    chk("b2_x", 32'(ifb.bullet_x[9:0]), 105);
    chk("b2_y", 32'(ifb.bullet_y[9:0]), 198);
    ifb.wall_bottom = 5'b00001;
    tick();
    ifb.wall_bottom = '0;
    chk("b3_active", 32'(ifb.active), 0);
    chk("b3_hold_x", 32'(ifb.bullet_x[9:0]), 105);
    chk("b3_hold_y", 32'(ifb.bullet_y[9:0]), 198);

    // Lifetime with a stationary bullet
    do_reset();
    ifa.cos = 8'h00; ifa.sin = 8'h00;
    pulse(0);
    n = ifa.active[0] ? 1 : 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (ifa.active[0]) n++;
      else break;
    end
    chk("lifetime", n, 1000);
    chk("life_hold_x", 32'(ifa.bullet_x[9:0]), 100);

    // Off-screen: spawn at x=638, next move lands on 640
    do_reset();
    ifa.tankX = 10'd631;
    pulse(0);
    chk("edge_x", 32'(ifa.bullet_x[9:0]), 638);
    chk("edge_active", 32'(ifa.active), 1);
    tick();
    chk("offscreen", 32'(ifa.active), 0);

    // Asynchronous reset mid-flight with three live slots
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i != 0) repeat (10) tick();
      pulse(0);
    end
    chk("three_live", 32'(ifa.active), 7);
    #2;
    rst = 1;
    #1;
    chk("async_active", 32'(ifa.active), 0);
    chk("async_x", 32'(ifa.bullet_x), 0);
    chk("async_y", 32'(ifa.bullet_y), 0);
    chk("async_ack", 32'(ifa.fire_ack), 0);
    tick();
    rst = 0;
    tick();
    pulse(0);
    chk("post_rst_ack", 32'(ifa.fire_ack), 1);
    chk("post_rst_active", 32'(ifa.active), 1);
    chk("post_rst_x", 32'(ifa.bullet_x[9:0]), 107);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
